// File: rtl/ef_spi_mc_pkg.sv
// Shared types and sizing helpers for the multi-chip-select SPI master.
package ef_spi_mc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } state_t;

  localparam int DW_MIN  = 4;
  localparam int DW_MAX  = 32;
  localparam int NCS_MIN = 1;
  localparam int NCS_MAX = 8;

  function automatic int level_w(input int faw);
    return faw + 1;
  endfunction

  function automatic int cs_w(input int ncs);
    return (ncs > 1) ? $clog2(ncs) : 1;
  endfunction

endpackage

// File: rtl/ef_spi_mc_fifo.sv
// Synchronous first-word-fall-through FIFO; push on full and pop on empty are ignored.
module ef_spi_mc_fifo
  import ef_spi_mc_pkg::*;
#(
  parameter int DW  = 8,
  parameter int FAW = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DW-1:0]           wdata,
  input  logic                    pop,
  output logic [DW-1:0]           rdata,
  output logic                    full,
  output logic                    empty,
  output logic [level_w(FAW)-1:0] level
);

  localparam int DEPTH = 2 ** FAW;

  logic [DW-1:0]  mem [DEPTH];
  logic [FAW-1:0] wr_ptr;
  logic [FAW-1:0] rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (level == {1'b1, {FAW{1'b0}}});
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // Head reads as zero while empty so the output is defined after reset.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ef_spi_mc_master.sv
// SPI master with N chip selects, CPOL/CPHA modes, SCK divider and TX/RX FIFOs.
// Optional LSB-first support is built when EF_SPI_MC_LSBF_EN is defined.
module ef_spi_mc_master
  import ef_spi_mc_pkg::*;
#(
  parameter int DW  = 8,
  parameter int NCS = 4,
  parameter int FAW = 3
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    enable,
  input  logic                    cpol,
  input  logic                    cpha,
`ifdef EF_SPI_MC_LSBF_EN
  input  logic                    lsbf,
`endif
  input  logic [7:0]              clk_div,
  input  logic [cs_w(NCS)-1:0]    cs_sel,
  input  logic                    cs_hold,
  input  logic [DW-1:0]           tx_data,
  input  logic                    tx_wr,
  input  logic                    rx_rd,
  output logic [DW-1:0]           rx_data,
  output logic                    tx_full,
  output logic                    tx_empty,
  output logic                    rx_full,
  output logic                    rx_empty,
  output logic [level_w(FAW)-1:0] tx_level,
  output logic [level_w(FAW)-1:0] rx_level,
  output logic                    busy,
  output logic                    done,
  output logic                    rx_ovf,
  input  logic                    MSI,
  output logic                    MSO,
  output logic                    SCK,
  output logic [NCS-1:0]          SSn
);

  localparam int CSW = cs_w(NCS);
  localparam int EW  = $clog2(2 * DW) + 1;
  localparam logic [EW-1:0] LAST_HP  = EW'(2 * DW - 1);
  localparam logic [EW-1:0] LAST_EDG = EW'(2 * DW);

  state_t         state;
  logic [7:0]     cnt;
  logic [7:0]     div_l;
  logic [EW-1:0]  hcnt;
  logic [EW-1:0]  e_num;
  logic           cpha_l;
  logic           lsbf_l;
  logic           lsbf_w;
  logic [DW-1:0]  tx_sh;
  logic [DW-1:0]  rx_sh;
  logic [DW-1:0]  tx_head;
  logic           hp_end;
  logic           start;
  logic           rx_push;
  logic           edge_now;
  logic           sample;
  logic           shift;

`ifdef EF_SPI_MC_LSBF_EN
  assign lsbf_w = lsbf;
`else
  assign lsbf_w = 1'b0;
`endif

  function automatic logic [NCS-1:0] cs_decode(input logic [CSW-1:0] sel);
    for (int i = 0; i < NCS; i++) cs_decode[i] = (sel != CSW'(i));
  endfunction

  ef_spi_mc_fifo #(.DW(DW), .FAW(FAW)) u_tx_fifo (
    .clk(CLK), .rst(RESET), .push(tx_wr), .wdata(tx_data), .pop(start),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  ef_spi_mc_fifo #(.DW(DW), .FAW(FAW)) u_rx_fifo (
    .clk(CLK), .rst(RESET), .push(rx_push), .wdata(rx_sh), .pop(rx_rd),
    .rdata(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  // Edge e (1..2*DW) closes half-period e-1; LEAD is half-period 0 and the
  // last SHIFT half-period closes without an edge, leaving SCK at idle.
  assign hp_end   = (cnt == 8'd0);
  assign start    = enable && !tx_empty &&
                    ((state == IDLE) || ((state == TRAIL) && hp_end && cs_hold));
  assign rx_push  = (state == SHIFT) && hp_end && (hcnt == LAST_HP);
  assign e_num    = (state == LEAD) ? EW'(1) : hcnt + EW'(2);
  assign edge_now = hp_end && ((state == LEAD) || ((state == SHIFT) && (hcnt != LAST_HP)));
  assign sample   = edge_now && (e_num[0] ^ cpha_l);
  assign shift    = edge_now && (cpha_l ? (e_num[0] && (e_num != EW'(1)))
                                        : (!e_num[0] && (e_num != LAST_EDG)));
  assign busy     = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (start)      tx_sh <= tx_head;
    else if (shift) tx_sh <= lsbf_l ? (tx_sh >> 1) : (tx_sh << 1);
    if (sample)     rx_sh <= lsbf_l ? {MSI, rx_sh[DW-1:1]} : {rx_sh[DW-2:0], MSI};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      div_l  <= '0;
      hcnt   <= '0;
      cpha_l <= 1'b0;
      lsbf_l <= 1'b0;
      SCK    <= 1'b0;
      MSO    <= 1'b0;
      SSn    <= '1;
      done   <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      done   <= 1'b0;
      rx_ovf <= 1'b0;
      if (start) begin
        state  <= LEAD;
        cnt    <= clk_div;
        div_l  <= clk_div;
        cpha_l <= cpha;
        lsbf_l <= lsbf_w;
        SCK    <= cpol;
        SSn    <= cs_decode(cs_sel);
        MSO    <= lsbf_w ? tx_head[0] : tx_head[DW-1];
      end else begin
        if (shift) MSO <= lsbf_l ? tx_sh[1] : tx_sh[DW-2];
        case (state)
          IDLE: SCK <= cpol;
          LEAD: begin
            if (hp_end) begin
              state <= SHIFT;
              hcnt  <= '0;
              cnt   <= div_l;
              SCK   <= ~SCK;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          SHIFT: begin
            if (hp_end) begin
              cnt <= div_l;
              if (hcnt == LAST_HP) begin
                state  <= TRAIL;
                done   <= 1'b1;
                rx_ovf <= rx_full;
              end else begin
                hcnt <= hcnt + 1'b1;
                SCK  <= ~SCK;
              end
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          TRAIL: begin
            if (hp_end) begin
              state <= GAP;
              cnt   <= div_l;
              SSn   <= '1;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          GAP: begin
            if (hp_end) state <= IDLE;
            else        cnt   <= cnt - 8'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
